snack_vend: RTL and testbench



---
 rtl/snack_vend_pkg.sv | 38 +++
 rtl/snack_vend_if.sv | 20 ++
 rtl/snack_vend_coin_edge.sv | 24 ++
 rtl/snack_vend.sv | 79 +++++++
 tb/tb_snack_vend.sv | 122 ++++++++++++
 5 files changed

// File: rtl/snack_vend_pkg.sv
// Shared constants for the 20c snack vending controller: state encodings,
// coin codes and pricing expressed in nickel units.
package snack_vend_pkg;

  // Each state encoding equals the credit held, counted in nickels.
  typedef enum logic [2:0] {
    S0  = 3'b000,
    S5  = 3'b001,
    S10 = 3'b010,
    S15 = 3'b011
  } state_t;

  localparam logic [2:0] COIN_NONE    = 3'b000;
  localparam logic [2:0] COIN_NICKEL  = 3'b001;
  localparam logic [2:0] COIN_DIME    = 3'b010;
  localparam logic [2:0] COIN_QUARTER = 3'b100;

  localparam int unsigned PRICE        = 20;
  localparam int unsigned NICKEL_CENTS = 5;
  localparam logic [3:0]  PRICE_N      = 4'(PRICE / NICKEL_CENTS);

  typedef struct packed {
    logic dispense;
    logic nickel;
    logic dime;
    logic ret;
  } pulses_t;

  function automatic logic [3:0] coin_nickels(input logic [2:0] code);
    case (code)
      COIN_NICKEL:  return 4'd1;
      COIN_DIME:    return 4'd2;
      COIN_QUARTER: return 4'd5;
      default:      return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/snack_vend_if.sv
// Coin acceptor / actuator bundle of the snack vending controller.
interface snack_vend_if;
  logic [2:0] coin_in;
  logic       out_nickel;
  logic       out_dime;
  logic       dispense_item;
  logic       out_return;
  logic [2:0] state_cur;
  logic [2:0] state_nxt;

  modport master (
    output coin_in,
    input  out_nickel, out_dime, dispense_item, out_return, state_cur, state_nxt
  );

  modport slave (
    input  coin_in,
    output out_nickel, out_dime, dispense_item, out_return, state_cur, state_nxt
  );
endinterface

// File: rtl/snack_vend_coin_edge.sv
// Detects a new coin insertion (idle -> non-idle) and classifies the code.
module snack_vend_coin_edge
  import snack_vend_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] coin_in,
  output logic       coin_event,
  output logic       coin_valid
);
  logic [2:0] coin_prev;

  // Reset to all-ones so a coin held through reset release is not counted.
  always_ff @(posedge clk) begin
    if (rst) coin_prev <= '1;
    else     coin_prev <= coin_in;
  end

  always_comb begin
    coin_event = (coin_prev == COIN_NONE) && (coin_in != COIN_NONE);
    coin_valid = (coin_in == COIN_NICKEL) || (coin_in == COIN_DIME) ||
                 (coin_in == COIN_QUARTER);
  end
endmodule

// File: rtl/snack_vend.sv
// 20c snack vending controller: credit FSM with registered one-cycle
// dispense, change and reject strobes.
module snack_vend
  import snack_vend_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  snack_vend_if.slave  bus
);
  state_t     state_q, state_d;
  pulses_t    pulse_q, pulse_d;
  logic       coin_event, coin_valid;
  logic [3:0] total, change;

  snack_vend_coin_edge u_coin_edge (
    .clk        (clk),
    .rst        (rst),
    .coin_in    (bus.coin_in),
    .coin_event (coin_event),
    .coin_valid (coin_valid)
  );

  // Transition table folded into nickel arithmetic: credit + coin either stays
  // below price (new credit) or its excess over price selects the change.
  always_comb begin
    state_d = state_q;
    pulse_d = '0;
    total   = '0;
    change  = '0;
    case (state_q)
      S0, S5, S10, S15: begin
        if (coin_event) begin
          if (!coin_valid) begin
            pulse_d.ret = 1'b1;
          end else begin
            total = {1'b0, state_q} + coin_nickels(bus.coin_in);
            if (total < PRICE_N) begin
              state_d = state_t'(total[2:0]);
            end else begin
              change = total - PRICE_N;
              case (change)
                4'd0: begin state_d = S0; pulse_d.dispense = 1'b1; end
                4'd1: begin state_d = S0; pulse_d.dispense = 1'b1; pulse_d.nickel = 1'b1; end
                4'd2: begin state_d = S0; pulse_d.dispense = 1'b1; pulse_d.dime = 1'b1; end
                4'd3: begin
                  state_d          = S0;
                  pulse_d.dispense = 1'b1;
                  pulse_d.dime     = 1'b1;
                  pulse_d.nickel   = 1'b1;
                end
                default: pulse_d.ret = 1'b1;
              endcase
            end
          end
        end
      end
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    bus.state_cur     = state_q;
    bus.state_nxt     = state_d;
    bus.dispense_item = pulse_q.dispense;
    bus.out_nickel    = pulse_q.nickel;
    bus.out_dime      = pulse_q.dime;
    bus.out_return    = pulse_q.ret;
  end
endmodule

// File: tb/tb_snack_vend.sv
// Directed scoreboard bench for snack_vend.
module tb_snack_vend;
  import snack_vend_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snack_vend_if bus();

  snack_vend dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [3:0] expq[$];
  logic [3:0] pulses;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_DISP = 4'b1000;
  localparam logic [3:0] P_DN   = 4'b1100;
  localparam logic [3:0] P_DD   = 4'b1010;
  localparam logic [3:0] P_DDN  = 4'b1110;
  localparam logic [3:0] P_RET  = 4'b0001;

  assign pulses = {bus.dispense_item, bus.out_nickel, bus.out_dime, bus.out_return};

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: every strobe activity must match the next queued expectation.
  always @(negedge clk) begin
    if (pulses !== P_NONE) begin
      if (expq.size() == 0) chk("unexpected_pulse", pulses, P_NONE);
      else                  chk("pulse", pulses, expq.pop_front());
    end
  end

  task automatic coin(input string name, input logic [2:0] code,
                      input logic [2:0] exp_state, input logic [3:0] exp_p);
    @(negedge clk);
    bus.coin_in = code;
    if (exp_p != P_NONE) expq.push_back(exp_p);
    #1 chk({name, "_nxt"}, {1'b0, bus.state_nxt}, {1'b0, exp_state});
    repeat (2) @(negedge clk);
    bus.coin_in = COIN_NONE;
    @(negedge clk);
    chk({name, "_state"}, {1'b0, bus.state_cur}, {1'b0, exp_state});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.coin_in = COIN_NICKEL;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {1'b0, bus.state_cur}, 4'd0);
    chk("reset_outputs", pulses, P_NONE);
    chk("held_coin_nxt", {1'b0, bus.state_nxt}, 4'd0);
    bus.coin_in = COIN_NONE;
    @(negedge clk);

    coin("nickel1", COIN_NICKEL, 3'b001, P_NONE);
    coin("nickel2", COIN_NICKEL, 3'b010, P_NONE);
    coin("s10_dime", COIN_DIME, 3'b000, P_DISP);
    coin("s0_quarter", COIN_QUARTER, 3'b000, P_DN);
    coin("dime", COIN_DIME, 3'b010, P_NONE);
    coin("nickel3", COIN_NICKEL, 3'b011, P_NONE);
    coin("s15_quarter", COIN_QUARTER, 3'b011, P_RET);
    coin("s15_nickel", COIN_NICKEL, 3'b000, P_DISP);
    coin("dime2", COIN_DIME, 3'b010, P_NONE);
    coin("s10_quarter", COIN_QUARTER, 3'b000, P_DDN);
    coin("nickel4", COIN_NICKEL, 3'b001, P_NONE);
    coin("s5_invalid", 3'b011, 3'b001, P_RET);
    coin("s5_dime", COIN_DIME, 3'b011, P_NONE);
    coin("s15_dime", COIN_DIME, 3'b000, P_DN);
    coin("nickel5", COIN_NICKEL, 3'b001, P_NONE);
    coin("s5_quarter", COIN_QUARTER, 3'b000, P_DD);
    coin("s0_invalid", 3'b111, 3'b000, P_RET);
    coin("s0_dime", COIN_DIME, 3'b010, P_NONE);
    coin("s10_nickel", COIN_NICKEL, 3'b011, P_NONE);

    // Reset mid-transaction drops credit with no refund.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_reset_state", {1'b0, bus.state_cur}, 4'd0);

    // Reset wins over a coin event in the same cycle; held coin ignored after.
    coin("nickel6", COIN_NICKEL, 3'b001, P_NONE);
    @(negedge clk);
    rst = 1'b1;
    bus.coin_in = COIN_DIME;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_coin_state", {1'b0, bus.state_cur}, 4'd0);
    bus.coin_in = COIN_NONE;
    @(negedge clk);
    coin("post_reset_nickel", COIN_NICKEL, 3'b001, P_NONE);

    repeat (3) @(negedge clk);
    chk("missing_pulses", 4'(expq.size()), 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
